// File: rtl/amber_pkg.sv
// rtl/amber_pkg.sv - shared widths, opcodes, capability type and decode helper for the Amber core
package amber_pkg;

  localparam int INSTR_W = 24;
  localparam int OPC_W   = 8;
  localparam int ADDR_W  = 48;
  localparam int PERM_W  = 24;
  localparam int ATTR_W  = 24;

  localparam logic [OPC_W-1:0] OPC_NOP  = 8'h00;
  localparam logic [OPC_W-1:0] OPC_CMOV = 8'h40;
  localparam logic [OPC_W-1:0] OPC_HLT  = 8'hFF;

  localparam int CR_PERM_R_BIT  = 0;
  localparam int CR_PERM_W_BIT  = 1;
  localparam int CR_PERM_X_BIT  = 2;
  localparam int CR_PERM_LC_BIT = 3;
  localparam int CR_PERM_SC_BIT = 4;
  localparam int CR_PERM_SB_BIT = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] cur;
    logic [PERM_W-1:0] perms;
    logic [ATTR_W-1:0] attr;
    logic              tag;
  } cap_t;

  localparam int CAP_W = $bits(cap_t);

  typedef enum logic [1:0] { OP_NOP, OP_CMOV, OP_HLT } op_e;
  typedef enum logic { ST_RUN, ST_HALT } run_e;

  // Anything that is not an exact CMOV/HLT match (unknown or X) decodes as NOP.
  function automatic op_e decode_op(input logic [OPC_W-1:0] opc);
    op_e op;
    op = OP_NOP;
    if (opc == OPC_CMOV) op = OP_CMOV;
    else if (opc == OPC_HLT) op = OP_HLT;
    return op;
  endfunction

endpackage

// File: rtl/amber_imem.sv
// rtl/amber_imem.sv - instruction word array with asynchronous read
module amber_imem
  import amber_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     iw_clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [INSTR_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [INSTR_W-1:0]       rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge iw_clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/amber_regcr.sv
// rtl/amber_regcr.sv - 4-entry capability register file, one async read port, one sync write port
module amber_regcr
  import amber_pkg::*;
(
  input  logic             iw_clk,
  input  logic             iw_rst,
  input  logic [1:0]       raddr,
  output logic [CAP_W-1:0] rdata,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [CAP_W-1:0] wdata
);

  logic [ADDR_W-1:0] r_base  [4];
  logic [ADDR_W-1:0] r_len   [4];
  logic [ADDR_W-1:0] r_cur   [4];
  logic [PERM_W-1:0] r_perms [4];
  logic [ATTR_W-1:0] r_attr  [4];
  logic              r_tag   [4];

  cap_t rd_cap;
  cap_t wr_cap;

  assign wr_cap = wdata;
  assign rdata  = rd_cap;

  always_comb begin
    rd_cap.base  = r_base[raddr];
    rd_cap.len   = r_len[raddr];
    rd_cap.cur   = r_cur[raddr];
    rd_cap.perms = r_perms[raddr];
    rd_cap.attr  = r_attr[raddr];
    rd_cap.tag   = r_tag[raddr];
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      for (int i = 0; i < 4; i++) begin
        r_base[i]  <= '0;
        r_len[i]   <= '0;
        r_cur[i]   <= '0;
        r_perms[i] <= '0;
        r_attr[i]  <= '0;
        r_tag[i]   <= 1'b0;
      end
    end else if (we) begin
      r_base[waddr]  <= wr_cap.base;
      r_len[waddr]   <= wr_cap.len;
      r_cur[waddr]   <= wr_cap.cur;
      r_perms[waddr] <= wr_cap.perms;
      r_attr[waddr]  <= wr_cap.attr;
      r_tag[waddr]   <= wr_cap.tag;
    end
  end

endmodule

// File: rtl/amber_cpu.sv
// rtl/amber_cpu.sv - 4-stage IF/ID/EX/WB capability core; AMBER_CR_BYPASS_EN selects forwarding over stalling
module amber_cpu
  import amber_pkg::*;
#(
  parameter int IMEM_DEPTH = 256
) (
  input  logic iw_clk,
  input  logic iw_rst
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);

  run_e               r_state, state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] imem_rdata;

  logic               r_ifid_valid;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic               r_idex_we;
  logic [1:0]         r_idex_rd;
  cap_t               r_idex_cap;
  logic               r_exwb_we;
  logic [1:0]         r_exwb_rd;
  cap_t               r_exwb_cap;

  op_e        id_op;
  logic [1:0] id_rd, id_rs;
  cap_t       cr_rdata, id_cap;
  logic       id_stall, fetch_en;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^r_ifid_instr[11:0];

  amber_imem #(.DEPTH(IMEM_DEPTH)) u_imem (
    .iw_clk (iw_clk),
    .we     (1'b0),
    .waddr  ({IMEM_AW{1'b0}}),
    .wdata  ({INSTR_W{1'b0}}),
    .raddr  (r_pc[IMEM_AW-1:0]),
    .rdata  (imem_rdata)
  );

  amber_regcr u_regcr (
    .iw_clk (iw_clk),
    .iw_rst (iw_rst),
    .raddr  (id_rs),
    .rdata  (cr_rdata),
    .we     (r_exwb_we),
    .waddr  (r_exwb_rd),
    .wdata  (r_exwb_cap)
  );

  always_comb begin
    id_op    = OP_NOP;
    id_rd    = r_ifid_instr[15:14];
    id_rs    = r_ifid_instr[13:12];
    id_cap   = cr_rdata;
    id_stall = 1'b0;
    if (r_ifid_valid) id_op = decode_op(r_ifid_instr[23:16]);
`ifdef AMBER_CR_BYPASS_EN
    // EX holds the younger of the two pending writes, so it wins.
    if (r_idex_we && r_idex_rd == id_rs) id_cap = r_idex_cap;
    else if (r_exwb_we && r_exwb_rd == id_rs) id_cap = r_exwb_cap;
`else
    if (id_op == OP_CMOV &&
        ((r_idex_we && r_idex_rd == id_rs) || (r_exwb_we && r_exwb_rd == id_rs)))
      id_stall = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = r_state;
    fetch_en  = 1'b0;
    if (r_state == ST_RUN) begin
      if (id_op == OP_HLT) state_nxt = ST_HALT;
      else if (!id_stall) fetch_en = 1'b1;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) r_state <= ST_RUN;
    else        r_state <= state_nxt;
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_pc         <= '0;
      r_ifid_valid <= 1'b0;
      r_idex_we    <= 1'b0;
      r_exwb_we    <= 1'b0;
    end else begin
      if (fetch_en) begin
        r_pc         <= r_pc + 48'd1;
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= imem_rdata;
      end else if (!id_stall) begin
        r_ifid_valid <= 1'b0;
      end
      r_idex_we  <= (id_op == OP_CMOV) && !id_stall;
      r_idex_rd  <= id_rd;
      r_idex_cap <= id_cap;
      r_exwb_we  <= r_idex_we;
      r_exwb_rd  <= r_idex_rd;
      r_exwb_cap <= r_idex_cap;
    end
  end

endmodule

// File: tb/tb_amber_cpu.sv
// tb/tb_amber_cpu.sv - scoreboard bench: directed and random programs against an instruction-level model
module tb_amber_cpu;
  import amber_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amber_cpu #(.IMEM_DEPTH(256)) dut (
    .iw_clk (clk),
    .iw_rst (rst)
  );

  typedef struct packed {
    logic [1:0] rd;
    cap_t       cap;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  int          wb_seen  = 0;
  bit          mon_en   = 1'b0;
  cap_t        init_cr  [4];
  cap_t        model_cr [4];
  logic [23:0] prog     [$];
  wr_t         exp_wr_q [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic cap_t mk_cap(input logic [47:0] b, input logic [47:0] l, input logic [47:0] c,
                                  input logic [23:0] p, input logic [23:0] a, input logic t);
    cap_t x;
    x.base = b; x.len = l; x.cur = c; x.perms = p; x.attr = a; x.tag = t;
    return x;
  endfunction

  function automatic cap_t rand_cap();
    return mk_cap({16'($urandom), $urandom}, {16'($urandom), $urandom}, {16'($urandom), $urandom},
                  24'($urandom), 24'($urandom), 1'($urandom));
  endfunction

  function automatic logic [23:0] cmov(input int rd, input int rs);
    return {OPC_CMOV, 2'(rd), 2'(rs), 12'($urandom)};
  endfunction

  function automatic cap_t act_cr(input int r);
    cap_t c;
    c.base  = dut.u_regcr.r_base[r];
    c.len   = dut.u_regcr.r_len[r];
    c.cur   = dut.u_regcr.r_cur[r];
    c.perms = dut.u_regcr.r_perms[r];
    c.attr  = dut.u_regcr.r_attr[r];
    c.tag   = dut.u_regcr.r_tag[r];
    return c;
  endfunction

  // Sequential, one-instruction-at-a-time semantics; every CMOV yields one expected write.
  task automatic model_run();
    for (int i = 0; i < prog.size(); i++) begin
      if (prog[i][23:16] == OPC_HLT) break;
      if (prog[i][23:16] == OPC_CMOV) begin
        model_cr[prog[i][15:14]] = model_cr[prog[i][13:12]];
        exp_wr_q.push_back({prog[i][15:14], model_cr[prog[i][15:14]]});
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && dut.r_exwb_we) begin
      wb_seen++;
      if (exp_wr_q.size() == 0) begin
        check($sformatf("wb%0d_unexpected", wb_seen), 1, 0);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check($sformatf("wb%0d_rd", wb_seen), dut.r_exwb_rd, e.rd);
        check($sformatf("wb%0d_cap", wb_seen), dut.r_exwb_cap, e.cap);
      end
    end
  end

  task automatic start_test();
    mon_en = 1'b0;
    rst = 1'b1;
    exp_wr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 256; i++)
      dut.u_imem.r_mem[i] <= (i < prog.size()) ? prog[i] : 24'h0;
    for (int r = 0; r < 4; r++) begin
      dut.u_regcr.r_base[r]  <= init_cr[r].base;
      dut.u_regcr.r_len[r]   <= init_cr[r].len;
      dut.u_regcr.r_cur[r]   <= init_cr[r].cur;
      dut.u_regcr.r_perms[r] <= init_cr[r].perms;
      dut.u_regcr.r_attr[r]  <= init_cr[r].attr;
      dut.u_regcr.r_tag[r]   <= init_cr[r].tag;
      model_cr[r] = init_cr[r];
    end
    model_run();
    mon_en = 1'b1;
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (dut.r_state != ST_HALT && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halted"}, dut.r_state == ST_HALT, 1);
    repeat (4) @(negedge clk);
    for (int r = 0; r < 4; r++)
      check($sformatf("%s_cr%0d", name, r), act_cr(r), model_cr[r]);
    check({name, "_pending_writes"}, exp_wr_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [47:0] pc_a;
    cap_t cr1;
    cr1 = mk_cap(48'd1000, 48'd88, 48'd1010, 24'h23, 24'h00A55A, 1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc", dut.r_pc, 0);
    check("rst_state", dut.r_state, ST_RUN);
    for (int r = 0; r < 4; r++) check($sformatf("rst_cr%0d", r), act_cr(r), 0);

    // Basic move
    init_cr = '{mk_cap(10, 20, 15, 0, 0, 0), cr1, '0, '0};
    prog = '{24'h000000, cmov(0, 1), {OPC_HLT, 16'h0}};
    start_test();
    wait_halt("move");

    // Back-to-back dependency
    init_cr = '{mk_cap(10, 20, 15, 0, 0, 0), cr1, '0, '0};
    prog = '{cmov(0, 1), cmov(2, 0), {OPC_HLT, 16'h0}};
    start_test();
    wait_halt("dep");
    check("dep_cr2_is_cr1", act_cr(2), cr1);

    // HLT squashes the younger CMOV
    prog = '{{OPC_HLT, 16'h0}, cmov(0, 1)};
    start_test();
    wait_halt("squash");
    pc_a = dut.r_pc;
    check("squash_pc", (pc_a == 48'd1) || (pc_a == 48'd2), 1);
    repeat (10) @(negedge clk);
    check("squash_pc_frozen", dut.r_pc, pc_a);

    // Undefined opcode behaves as NOP
    init_cr = '{'0, cr1, rand_cap(), rand_cap()};
    prog = '{{8'h12, 16'hFFFF}, cmov(3, 1), {OPC_HLT, 16'h0}};
    start_test();
    wait_halt("undef");
    check("undef_cr3_is_cr1", act_cr(3), cr1);

    // Self-move
    init_cr = '{rand_cap(), rand_cap(), mk_cap(5, 6, 7, 24'h1, 24'h2, 1'b1), rand_cap()};
    prog = '{cmov(2, 2), {OPC_HLT, 16'h0}};
    start_test();
    wait_halt("self");
    check("self_cr2", act_cr(2), mk_cap(5, 6, 7, 24'h1, 24'h2, 1'b1));

    // Reset while a CMOV is in EX
    init_cr = '{'0, cr1, '0, '0};
    prog = '{cmov(0, 1), {OPC_HLT, 16'h0}};
    start_test();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_wr_q.delete();
    @(negedge clk);
    check("mid_rst_pc", dut.r_pc, 0);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("mid_rst_cr%0d", r), act_cr(r), 0);
      model_cr[r] = '0;
    end
    model_run();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_restart_pc", dut.r_pc, 1);
    wait_halt("mid_rst");

    // Random programs: mixed CMOV/NOP/undefined, HLT, then a CMOV that must be squashed
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < 4; r++) init_cr[r] = rand_cap();
      prog.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) begin
        case ($urandom_range(0, 9))
          0, 1:    prog.push_back(24'h000000);
          2, 3:    prog.push_back({8'($urandom_range(1, 63)), 16'($urandom)});
          default: prog.push_back(cmov($urandom_range(0, 3), $urandom_range(0, 3)));
        endcase
      end
      prog.push_back({OPC_HLT, 16'($urandom)});
      prog.push_back(cmov($urandom_range(0, 3), $urandom_range(0, 3)));
      start_test();
      wait_halt($sformatf("rnd%0d", t));
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
